// File: rtl/serial_link_credit_ctrl_if.sv
// Bundle of the stream, link and debug signals around one credit-controlled
// link end. The width of the credit fields comes from NumCredits.
//   slave  : seen by serial_link_credit_ctrl (suffix _i = into the controller)
//   master : seen by whatever drives the controller (bridge, link, bench)
// Signals:
//   data_in_*   outgoing beats from the bridge (valid/ready/payload)
//   link_out_*  beats to the link: valid/ready, payload, data flag, credits
//   link_in_*   beats from the link (no backpressure): valid, data flag,
//               returned credits, payload
//   data_out_*  rx FIFO head towards the bridge (valid/ready/payload)
//   credits_o   current send credits, overflow_o sticky rx overflow
interface serial_link_credit_ctrl_if #(
   parameter int NumCredits = 8,
   parameter int DataWidth  = 577
);
   localparam int CntW = $clog2(NumCredits + 1);

   logic                 data_in_valid_i;
   logic                 data_in_ready_o;
   logic [DataWidth-1:0] data_in_i;

   logic                 link_out_valid_o;
   logic                 link_out_ready_i;
   logic [DataWidth-1:0] link_out_data_o;
   logic                 link_out_data_vld_o;
   logic [CntW-1:0]      link_out_credits_o;

   logic                 link_in_valid_i;
   logic                 link_in_data_vld_i;
   logic [CntW-1:0]      link_in_credits_i;
   logic [DataWidth-1:0] link_in_data_i;

   logic                 data_out_valid_o;
   logic                 data_out_ready_i;
   logic [DataWidth-1:0] data_out_o;

   logic [CntW-1:0]      credits_o;
   logic                 overflow_o;

   modport slave (
      input  data_in_valid_i, data_in_i, link_out_ready_i,
             link_in_valid_i, link_in_data_vld_i, link_in_credits_i,
             link_in_data_i, data_out_ready_i,
      output data_in_ready_o, link_out_valid_o, link_out_data_o,
             link_out_data_vld_o, link_out_credits_o, data_out_valid_o,
             data_out_o, credits_o, overflow_o
   );

   modport master (
      output data_in_valid_i, data_in_i, link_out_ready_i,
             link_in_valid_i, link_in_data_vld_i, link_in_credits_i,
             link_in_data_i, data_out_ready_i,
      input  data_in_ready_o, link_out_valid_o, link_out_data_o,
             link_out_data_vld_o, link_out_credits_o, data_out_valid_o,
             data_out_o, credits_o, overflow_o
   );
endinterface

// File: rtl/serial_link_credit_ctrl.sv
// Credit-based flow control for one end of a serial link.
// Outgoing beats are gated on send credits mirroring the remote rx buffer;
// every outgoing beat piggybacks credits for slots freed in the local rx
// FIFO, and a credit-only beat is forced once enough returns pile up.
// Ports:
//   clk_i  clock
//   rst_i  synchronous reset, active-high
//   lnk    serial_link_credit_ctrl_if.slave (see interface file)
//
// Outgoing arbiter states:
//   state     | meaning
//   ST_IDLE   | nothing held; a beat may be chosen and presented this cycle
//   ST_DATA   | data beat presented earlier, stalled by link_out_ready_i=0
//   ST_CREDIT | credit-only beat presented earlier, stalled
module serial_link_credit_ctrl #(
   parameter  int NumCredits      = 8,
   parameter  int ForceSendThresh = 4,
   parameter  int DataWidth       = 577,
   localparam int CntW            = $clog2(NumCredits + 1)
) (
   input logic                      clk_i,
   input logic                      rst_i,
   serial_link_credit_ctrl_if.slave lnk
);

   localparam int              PtrW     = $clog2(NumCredits);
   localparam logic [CntW-1:0] MAX_CRED = CntW'(NumCredits);
   localparam logic [CntW-1:0] THRESH   = CntW'(ForceSendThresh);
   localparam logic [PtrW-1:0] LAST_PTR = PtrW'(NumCredits - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_CREDIT = 2'd2
   } state_t;

   state_t          state_q, state_d, beat_sel;
   logic            hs, data_hs;

   logic [CntW-1:0] credits_q, credits_d;
   logic [CntW:0]   cred_sum;
   logic [CntW-1:0] pending_q, pending_d;
   logic [CntW-1:0] snap_q, credits_out;

   logic [DataWidth-1:0] mem [NumCredits];
   logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0]      fill_q;
   logic                 overflow_q;
   logic                 full, pop, wr_req, push, drop;

   // beat_sel is the kind of beat on link_out this cycle. From idle the
   // choice is combinational so a beat can go out in the cycle right after
   // the previous handshake, which sustains one beat per cycle.
   always_comb begin
      beat_sel = ST_IDLE;
      case (state_q)
         ST_IDLE: begin
            if (lnk.data_in_valid_i && (credits_q != '0)) begin
               beat_sel = ST_DATA;
            end else if (pending_q >= THRESH) begin
               beat_sel = ST_CREDIT;
            end
         end
         ST_DATA:   beat_sel = ST_DATA;
         ST_CREDIT: beat_sel = ST_CREDIT;
         default:   beat_sel = ST_IDLE;
      endcase
      hs      = (beat_sel != ST_IDLE) && lnk.link_out_ready_i;
      data_hs = hs && (beat_sel == ST_DATA);
      state_d = hs ? ST_IDLE : beat_sel;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // While idle the credit field tracks pending_q live; once a beat stalls
   // the value it was presented with is frozen in snap_q.
   assign credits_out = (state_q == ST_IDLE) ? pending_q : snap_q;

   always_comb begin
      cred_sum = {1'b0, credits_q};
      if (lnk.link_in_valid_i) begin
         cred_sum = cred_sum + {1'b0, lnk.link_in_credits_i};
      end
      if (data_hs) begin
         cred_sum = cred_sum - (CntW+1)'(1);
      end
      credits_d = (cred_sum > {1'b0, MAX_CRED}) ? MAX_CRED : cred_sum[CntW-1:0];

      // Pops during a stall stay in pending_q; only the advertised amount
      // is retired on the handshake.
      pending_d = pending_q + CntW'(pop);
      if (hs) begin
         pending_d = pending_d - credits_out;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         credits_q <= MAX_CRED;
         pending_q <= '0;
         snap_q    <= '0;
      end else begin
         credits_q <= credits_d;
         pending_q <= pending_d;
         if (state_q == ST_IDLE) begin
            snap_q <= pending_q;
         end
      end
   end

   a_credit_limit : assert property (@(posedge clk_i) disable iff (rst_i)
      cred_sum <= {1'b0, MAX_CRED});

   // Receive FIFO. A push into a full FIFO is accepted when a pop frees the
   // slot in the same cycle; the read side still shows the old head then.
   assign full   = (fill_q == MAX_CRED);
   assign pop    = (fill_q != '0) && lnk.data_out_ready_i;
   assign wr_req = lnk.link_in_valid_i && lnk.link_in_data_vld_i;
   assign push   = wr_req && (!full || pop);
   assign drop   = wr_req && full && !pop;

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr_q] <= lnk.link_in_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         fill_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PtrW'(1);
         end
         fill_q     <= fill_q + CntW'(push) - CntW'(pop);
         overflow_q <= overflow_q | drop;
      end
   end

   assign lnk.link_out_valid_o    = (beat_sel != ST_IDLE);
   assign lnk.link_out_data_vld_o = (beat_sel == ST_DATA);
   assign lnk.link_out_data_o     = lnk.data_in_i;
   assign lnk.link_out_credits_o  = credits_out;
   assign lnk.data_in_ready_o     = (beat_sel == ST_DATA) && lnk.link_out_ready_i
                                    && (credits_q != '0);

   assign lnk.data_out_valid_o = (fill_q != '0);
   assign lnk.data_out_o       = mem[rd_ptr_q];
   assign lnk.credits_o        = credits_q;
   assign lnk.overflow_o       = overflow_q;

endmodule

// File: doc/serial_link_credit_ctrl.md
Name: serial_link_credit_ctrl

Overview:
Credit-based flow-control stage directly downstream of the NoC-to-AXIS bridge's outgoing stream and upstream of its incoming stream. It gates outgoing beats on credits that mirror the remote receive buffer. Each outgoing beat piggybacks returned credits. Incoming data beats go into a local receive FIFO of depth NumCredits, and each pop from it produces one credit for the remote side. The block is instantiated once per link end, so both ends run the same protocol.

Parameters:
NumCredits, 8, depth of local rx FIFO = initial send credits; must be >= 2
ForceSendThresh, 4, pending-return count that triggers a credit-only beat; 1..NumCredits
DataWidth, 577, width of one beat (bridge payload incl. header)
CntW, $clog2(NumCredits+1), derived credit field width, not overridable

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
data_in_valid_i  in  1  beat from bridge valid
data_in_ready_o  out  1  beat accepted
data_in_i  in  DataWidth  beat payload
link_out_valid_o  out  1  beat to link valid
link_out_ready_i  in  1  link accepts beat
link_out_data_o  out  DataWidth  payload (don't-care if link_out_data_vld_o=0)
link_out_data_vld_o  out  1  1=data beat, 0=credit-only beat
link_out_credits_o  out  CntW  credits returned to remote
link_in_valid_i  in  1  beat from link (no backpressure)
link_in_data_vld_i  in  1  beat carries data
link_in_credits_i  in  CntW  credits returned by remote
link_in_data_i  in  DataWidth  payload
data_out_valid_o  out  1  rx FIFO head valid, to bridge
data_out_ready_i  in  1  bridge pops
data_out_o  out  DataWidth  rx FIFO head
credits_o  out  CntW  current send credits (debug)
overflow_o  out  1  sticky protocol error

Behaviour:
- Reset (sync, rst_i=1 at a clock edge):
  - credits_q=NumCredits, pending_q=0, rx FIFO empty, overflow_o=0.
  - data_out_valid_o=0, link_out_valid_o=0, credits_o=NumCredits.
  - Reset mid-operation discards the FIFO contents and any stalled beat.
- Send credits:
  - credits_d = credits_q + (link_in_valid_i ? link_in_credits_i : 0) - (data beat handshake on link_out).
  - A simultaneous return and send is applied in the same cycle.
  - Exceeding NumCredits is an assertion failure; the counter saturates at NumCredits.
- Outgoing arbitration, FSM with states IDLE, DATA, CREDIT:
  - IDLE: if data_in_valid_i and credits_q>0, present a data beat and go to DATA. Else if pending_q>=ForceSendThresh, present a credit-only beat and go to CREDIT.
  - DATA: a data beat is presented. link_out_data_o = data_in_i, data_in_ready_o = link_out_ready_i.
  - CREDIT: a credit-only beat is presented. data_in_ready_o=0.
  - A presented beat holds until the link_out handshake; data never preempts a presented credit-only beat. After the handshake, re-evaluate the IDLE conditions in the same cycle for back-to-back operation (1 beat/cycle sustained).
  - data_in_ready_o=0 whenever credits_q=0.
- Credit return:
  - Each rx FIFO pop increments pending_q.
  - When a beat becomes presented, link_out_credits_o snapshots pending_q and holds it, stable while stalled.
  - On handshake, pending_d = pending_q - snapshot + (pop this cycle).
  - Pops during a stall accumulate and are never lost or double-counted.
- Receive path:
  - link_in_valid_i & link_in_data_vld_i pushes link_in_data_i.
  - Read latency from push to data_out_valid_o is 1 cycle.
  - Push and pop in the same cycle are allowed at any occupancy, including full.
  - A push when full without a same-cycle pop is dropped and sets overflow_o, which stays high until reset.
  - Credit-only beats never push.
- data_out_o stays stable while data_out_valid_o & !data_out_ready_i.
- Deadlock freedom: ForceSendThresh<=NumCredits guarantees that a remote sender at 0 credits is eventually refilled.

Test Plan:
- Reset, then 8 data beats with link_out_ready_i=1 and no returns -> 8 handshakes back-to-back; credits_o 8→0; 9th beat stalls with data_in_ready_o=0.
- At credits_o=0, link_in_valid_i=1 with link_in_credits_i=3 and no data -> credits_o=3 next cycle; 3 more beats pass, then stall.
- Push 4 beats into rx FIFO, pop 4 with no outgoing data -> one credit-only beat (link_out_data_vld_o=0, link_out_credits_o=4); pending returns to 0.
- Credit-only beat stalled with link_out_ready_i=0 for 5 cycles while 2 more pops occur -> link_out_credits_o stays 4 and valid stays high; on handshake pending_q=2; data_in held off during the stall.
- Fill rx FIFO to 8, push a 9th without pop -> beat dropped, overflow_o=1 until rst_i. Repeat with a simultaneous pop -> no overflow, FIFO stays at 8.
- Assert rst_i mid-burst with FIFO at 5 and a stalled beat -> next cycle credits_o=8, data_out_valid_o=0, link_out_valid_o=0, overflow_o=0.
